cascade_four_bit_comparator: RTL and testbench
==============================================

Name: cascade_four_bit_comparator

Overview:
- Unsigned magnitude comparator for M-bit operands, built as a chain of 4-bit comparator slices in the style of a 7485 cascade.
- Each slice passes its result to the next more-significant slice.
- One result register stage follows the chain, giving three one-hot flags: a==b, a<b, a>b.
- Used wherever a registered compare result is needed, e.g. threshold/limit checks in datapaths.

Parameters:
- M, default 1: operand width in bits, M >= 1. Slice count K = ceil(M/4); the top slice is zero-padded when M is not a multiple of 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- valid_i  input  1  operands on a/b are valid this cycle; result register loads only when high
- a  input  M  operand A, unsigned
- b  input  M  operand B, unsigned
- aEQb  output  1  registered: a == b
- aLTb  output  1  registered: a < b
- aGTb  output  1  registered: a > b
- valid_o  output  1  registered copy of valid_i; high the cycle the flags reflect a newly loaded compare
- (CMP_CASCADE_IN_EN only) casc_eq_i, casc_lt_i, casc_gt_i  input  1 each  cascade inputs from a less-significant external comparator

Behaviour:
- Reset is asynchronous and active-high.
  - While rst=1: aEQb=1, aLTb=0, aGTb=0, valid_o=0.
  - Release takes effect at the first clk edge with rst=0.
- Slicing:
  - Zero-extend a and b to 4K bits.
  - Slice i covers bits [4i+3:4i]; slice 0 is least significant.
- Slice function, given cascade inputs (eq, lt, gt):
  - a_i > b_i -> (0,0,1).
  - a_i < b_i -> (0,1,0).
  - a_i == b_i -> pass the cascade inputs through unchanged.
- Chain:
  - Slice 0 cascade input is the constant (eq=1, lt=0, gt=0).
  - Slice i>0 cascade input is the output of slice i-1.
  - Result is the output of slice K-1.
  - Net effect: exact unsigned comparison; the most significant differing slice decides.
- Register stage:
  - On the rising clk edge with valid_i=1, the flags load the chain result.
  - With valid_i=0, the flags hold their previous values.
  - valid_o <= valid_i every cycle.
- Latency: 1 clock from valid_i/a/b sampled to flags/valid_o.
- Throughput: one compare per cycle; back-to-back valid_i is allowed.
- Invariant: exactly one of aEQb/aLTb/aGTb is 1 at all times, including during and after reset.
- The flags must be equivalent to (a==b, a<b, a>b) on the zero-extended unsigned values.
- The chain is combinational; no internal pipelining between slices.
- Boundary cases:
  - M=1 -> single slice with bits [3:1] padded to 0.
  - M=4 -> one unpadded slice.
  - Operands all-zeros vs all-ones -> LT or GT from the top slice alone.
  - Reset asserted mid-stream -> flags return to the EQ reset value immediately, and valid_o drops immediately.

Optional Feature:
- Macro CMP_CASCADE_IN_EN.
- Defined:
  - Adds ports casc_eq_i/casc_lt_i/casc_gt_i.
  - Slice 0 cascade input is taken from these ports instead of the constant (1,0,0).
  - This allows wider words to be built from multiple instances.
  - If the cascade inputs are not one-hot, behaviour is unspecified.
- Undefined:
  - The ports do not exist.
  - Slice 0 uses the constant EQ cascade.

Test Plan:
- Reset, M=8: assert rst with a=8'h55, b=8'h10, valid_i=1 -> flags (EQ,LT,GT)=(1,0,0) and valid_o=0 throughout. Deassert -> next edge gives (0,0,1), valid_o=1.
- M=8, cross-slice: a=8'h1F, b=8'h20 -> upper slice decides -> (0,1,0). Then a=8'h30, b=8'h2F -> (0,0,1). Then a=8'hA7, b=8'hA7 -> (1,0,0). Each result appears exactly 1 cycle after the stimulus.
- Hold: load a=3, b=9 (M=4) -> (0,1,0). Then drive valid_i=0 with a=9, b=3 for 3 cycles -> flags stay (0,1,0), valid_o=0.
- M=1: the four combinations (0,0), (0,1), (1,0), (1,1) -> EQ, LT, GT, EQ.
- M=6 padding: a=6'h3F, b=6'h00 -> GT; a=6'h20, b=6'h1F -> GT; a=6'h00, b=6'h3F -> LT.
- Random, M=13: 1000 back-to-back random pairs -> flags match a reference compare, delayed 1 cycle, with the one-hot invariant checked every cycle. With CMP_CASCADE_IN_EN and equal operands, casc_lt_i=1 -> LT.

Source files
------------

// File: rtl/cascade_four_bit_comparator.sv
// Registered unsigned magnitude comparator built from a chain of 7485-style 4-bit slices.
// Optional macro CMP_CASCADE_IN_EN adds external cascade inputs feeding the least significant slice.
module cascade_four_bit_comparator #(
    parameter int M = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
`ifdef CMP_CASCADE_IN_EN
    input  logic         casc_eq_i,
    input  logic         casc_lt_i,
    input  logic         casc_gt_i,
`endif
    output logic         aEQb,
    output logic         aLTb,
    output logic         aGTb,
    output logic         valid_o
);

    localparam int K = (M + 3) / 4;

    // Cascade bundle encoding is {eq, lt, gt}.
    function automatic logic [2:0] slice_cmp(input logic [3:0] sa,
                                             input logic [3:0] sb,
                                             input logic [2:0] cin);
        if (sa > sb)
            return 3'b001;
        else if (sa < sb)
            return 3'b010;
        else
            return cin;
    endfunction

    logic [4*K-1:0] w_a_ext;
    logic [4*K-1:0] w_b_ext;
    logic [2:0]     w_casc [K+1];
    logic [2:0]     r_flags;
    logic           r_valid;

    assign w_a_ext = (4*K)'(a);
    assign w_b_ext = (4*K)'(b);

`ifdef CMP_CASCADE_IN_EN
    assign w_casc[0] = {casc_eq_i, casc_lt_i, casc_gt_i};
`else
    assign w_casc[0] = 3'b100;
`endif

    // Slice i compares bits [4i+3:4i]; the most significant differing slice wins.
    for (genvar i = 0; i < K; i++) begin : g_slice
        assign w_casc[i+1] = slice_cmp(w_a_ext[4*i +: 4], w_b_ext[4*i +: 4], w_casc[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the reset value is EQ rather than all-zero so the flags stay one-hot at all times.
        if (rst) begin
            r_flags <= 3'b100;
            r_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_valid <= valid_i;
            if (valid_i)
                r_flags <= w_casc[K];
        end
    end

    assign aEQb    = r_flags[2];
    assign aLTb    = r_flags[1];
    assign aGTb    = r_flags[0];
    assign valid_o = r_valid;

endmodule

// File: tb/tb_cascade_four_bit_comparator.sv
// Self-checking bench: instances at M=8,4,1,6,13 driven by directed tables, hand sequences and a random run.
module tb_cascade_four_bit_comparator;

    typedef struct {
        int          inst;
        logic [12:0] a;
        logic [12:0] b;
        logic [2:0]  exp;   // {eq, lt, gt}
    } vec_t;

    logic        clk;
    logic        rst;
    logic [4:0]  v_in;
    logic [12:0] a_in [5];
    logic [12:0] b_in [5];
    wire  [4:0]  eq_o;
    wire  [4:0]  lt_o;
    wire  [4:0]  gt_o;
    wire  [4:0]  vo_o;
    logic        casc_eq;
    logic        casc_lt;
    logic        casc_gt;

    int n_checks;
    int n_errors;
    vec_t vecs [14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CMP_CASCADE_IN_EN
  `define TB_CASC .casc_eq_i(casc_eq), .casc_lt_i(casc_lt), .casc_gt_i(casc_gt),
`else
  `define TB_CASC
`endif

    cascade_four_bit_comparator #(.M(8)) u_m8 (
        .clk(clk), .rst(rst), .valid_i(v_in[0]), .a(a_in[0][7:0]), .b(b_in[0][7:0]), `TB_CASC
        .aEQb(eq_o[0]), .aLTb(lt_o[0]), .aGTb(gt_o[0]), .valid_o(vo_o[0]));
    cascade_four_bit_comparator #(.M(4)) u_m4 (
        .clk(clk), .rst(rst), .valid_i(v_in[1]), .a(a_in[1][3:0]), .b(b_in[1][3:0]), `TB_CASC
        .aEQb(eq_o[1]), .aLTb(lt_o[1]), .aGTb(gt_o[1]), .valid_o(vo_o[1]));
    cascade_four_bit_comparator #(.M(1)) u_m1 (
        .clk(clk), .rst(rst), .valid_i(v_in[2]), .a(a_in[2][0:0]), .b(b_in[2][0:0]), `TB_CASC
        .aEQb(eq_o[2]), .aLTb(lt_o[2]), .aGTb(gt_o[2]), .valid_o(vo_o[2]));
    cascade_four_bit_comparator #(.M(6)) u_m6 (
        .clk(clk), .rst(rst), .valid_i(v_in[3]), .a(a_in[3][5:0]), .b(b_in[3][5:0]), `TB_CASC
        .aEQb(eq_o[3]), .aLTb(lt_o[3]), .aGTb(gt_o[3]), .valid_o(vo_o[3]));
    cascade_four_bit_comparator #(.M(13)) u_m13 (
        .clk(clk), .rst(rst), .valid_i(v_in[4]), .a(a_in[4]), .b(b_in[4]), `TB_CASC
        .aEQb(eq_o[4]), .aLTb(lt_o[4]), .aGTb(gt_o[4]), .valid_o(vo_o[4]));

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {eq,lt,gt,valid}=%b expected %b", name, got, exp);
        end
    endtask

    function automatic logic [3:0] outs(input int inst);
        return {eq_o[inst], lt_o[inst], gt_o[inst], vo_o[inst]};
    endfunction

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        casc_eq  = 1'b1;
        casc_lt  = 1'b0;
        casc_gt  = 1'b0;
        v_in     = '0;
        for (int i = 0; i < 5; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end

        vecs[0]  = '{0, 13'h1F, 13'h20, 3'b010};
        vecs[1]  = '{0, 13'h30, 13'h2F, 3'b001};
        vecs[2]  = '{0, 13'hA7, 13'hA7, 3'b100};
        vecs[3]  = '{0, 13'h00, 13'hFF, 3'b010};
        vecs[4]  = '{0, 13'hFF, 13'h00, 3'b001};
        vecs[5]  = '{2, 13'h0,  13'h0,  3'b100};
        vecs[6]  = '{2, 13'h0,  13'h1,  3'b010};
        vecs[7]  = '{2, 13'h1,  13'h0,  3'b001};
        vecs[8]  = '{2, 13'h1,  13'h1,  3'b100};
        vecs[9]  = '{3, 13'h3F, 13'h00, 3'b001};
        vecs[10] = '{3, 13'h20, 13'h1F, 3'b001};
        vecs[11] = '{3, 13'h00, 13'h3F, 3'b010};
        vecs[12] = '{1, 13'h0,  13'hF,  3'b010};
        vecs[13] = '{1, 13'hF,  13'hF,  3'b100};

        // Reset held with a GT-producing operand pair and valid high.
        rst     = 1'b1;
        a_in[0] = 13'h55;
        b_in[0] = 13'h10;
        v_in[0] = 1'b1;
        #1;
        check("reset_t0", outs(0), 4'b1000);
        step();
        check("reset_c1", outs(0), 4'b1000);
        step();
        check("reset_c2", outs(0), 4'b1000);
        rst = 1'b0;
        step();
        check("reset_release_gt", outs(0), 4'b0011);

        // Reset asserted mid-stream must act without waiting for a clock edge.
        rst = 1'b1;
        #1;
        check("reset_midstream", outs(0), 4'b1000);
        step();
        rst     = 1'b0;
        v_in[0] = 1'b0;
        step();

        for (int i = 0; i < 14; i++) begin
            v_in = '0;
            v_in[vecs[i].inst] = 1'b1;
            a_in[vecs[i].inst] = vecs[i].a;
            b_in[vecs[i].inst] = vecs[i].b;
            step();
            check($sformatf("vec%0d_inst%0d", i, vecs[i].inst), outs(vecs[i].inst), {vecs[i].exp, 1'b1});
        end
        v_in = '0;

        // Hold: flags keep LT while valid_i is low even though operands now say GT.
        v_in[1] = 1'b1;
        a_in[1] = 13'd3;
        b_in[1] = 13'd9;
        step();
        check("hold_load", outs(1), 4'b0101);
        v_in[1] = 1'b0;
        a_in[1] = 13'd9;
        b_in[1] = 13'd3;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("hold_c%0d", c), outs(1), 4'b0100);
        end

        // Random back-to-back traffic on the 13-bit instance.
        v_in[4] = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [12:0] ra;
            logic [12:0] rb;
            logic [2:0]  ex;
            ra = 13'($urandom_range(0, 8191));
            case (i % 4)
                0: rb = ra;
                1: rb = ra ^ 13'(1 << $urandom_range(0, 12));
                default: rb = 13'($urandom_range(0, 8191));
            endcase
            a_in[4] = ra;
            b_in[4] = rb;
            ex = {ra == rb, ra < rb, ra > rb};
            step();
            check($sformatf("rand%0d", i), outs(4), {ex, 1'b1});
            n_checks++;
            if (!$onehot({eq_o[4], lt_o[4], gt_o[4]})) begin
                n_errors++;
                $display("FAIL onehot%0d: got %b expected one-hot", i, {eq_o[4], lt_o[4], gt_o[4]});
            end
        end

`ifdef CMP_CASCADE_IN_EN
        a_in[4] = 13'h1234;
        b_in[4] = 13'h1234;
        casc_eq = 1'b0;
        casc_lt = 1'b1;
        step();
        check("casc_lt_in", outs(4), 4'b0101);
        casc_lt = 1'b0;
        casc_gt = 1'b1;
        step();
        check("casc_gt_in", outs(4), 4'b0011);
        b_in[4] = 13'h1235;
        step();
        check("casc_overridden", outs(4), 4'b0101);
        casc_eq = 1'b1;
        casc_gt = 1'b0;
`endif
        v_in = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
